// File: rtl/gcd_requester.sv
// Request generator and result collector for the GCD unit: issues a programmed
// number of operand pairs, one at a time, and accumulates count/checksum/last result.
module gcd_requester #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [31:0] SEED    = 32'hACE1_0001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             use_ext,
    input  logic [WIDTH-1:0] ext_x,
    input  logic [WIDTH-1:0] ext_y,
    input  logic [15:0]      num_req,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_x,
    output logic [WIDTH-1:0] req_y,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_bits,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      resp_count,
    output logic [WIDTH-1:0] checksum,
    output logic [WIDTH-1:0] last_result
);

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int unsigned TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_step;
    logic [15:0]      num_q;
    logic             use_ext_q;
    logic [WIDTH-1:0] ext_x_q;
    logic [WIDTH-1:0] ext_y_q;
    logic [TW-1:0]    tcount;
    logic [WIDTH-1:0] lfsr_x;
    logic [WIDTH-1:0] lfsr_y;
    logic [15:0]      count_inc;

    assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    // Both LFSR-derived operands have bit 0 forced high so neither is ever zero.
    assign lfsr_x    = lfsr[WIDTH-1:0] | WIDTH'(1);
    assign lfsr_y    = ~lfsr[WIDTH-1:0] | WIDTH'(1);
    assign count_inc = resp_count + 16'd1;

    assign busy  = (state == S_SEND) || (state == S_WAIT);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            num_q       <= '0;
            use_ext_q   <= 1'b0;
            ext_x_q     <= '0;
            ext_y_q     <= '0;
            tcount      <= '0;
            req_valid   <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            resp_count  <= '0;
            checksum    <= '0;
            last_result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // A spurious result outranks a simultaneous start.
                    if (rsp_valid) begin
                        state <= S_ERR;
                    end else if (start) begin
                        num_q       <= num_req;
                        use_ext_q   <= use_ext;
                        ext_x_q     <= ext_x;
                        ext_y_q     <= ext_y;
                        resp_count  <= '0;
                        checksum    <= '0;
                        last_result <= '0;
                        if (num_req == 16'd0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_SEND;
                            req_valid <= 1'b1;
                            req_x     <= use_ext ? ext_x : lfsr_x;
                            req_y     <= use_ext ? ext_y : lfsr_y;
                        end
                    end
                end
                S_SEND: begin
                    if (rsp_valid) begin
                        state     <= S_ERR;
                        req_valid <= 1'b0;
                    end else if (req_ready) begin
                        state     <= S_WAIT;
                        req_valid <= 1'b0;
                        tcount    <= '0;
                        lfsr      <= lfsr_step;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        checksum    <= checksum + rsp_bits;
                        resp_count  <= count_inc;
                        last_result <= rsp_bits;
                        if (count_inc == num_q) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_SEND;
                            req_valid <= 1'b1;
                            req_x     <= use_ext_q ? ext_x_q : lfsr_x;
                            req_y     <= use_ext_q ? ext_y_q : lfsr_y;
                        end
                    end else if (tcount == TLAST) begin
                        state <= S_ERR;
                    end else begin
                        tcount <= tcount + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester: the bench plays the GCD side of both handshakes
// and checks counters, operands and state flags against hand-computed values.
module tb_gcd_requester;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        use_ext;
    logic [31:0] ext_x;
    logic [31:0] ext_y;
    logic [15:0] num_req;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        rsp_valid;
    logic [31:0] rsp_bits;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] resp_count;
    logic [31:0] checksum;
    logic [31:0] last_result;

    int n_assert = 0;
    int n_fail   = 0;
    int fires    = 0;
    int f0;

    gcd_requester #(
        .WIDTH   (32),
        .TIMEOUT (16),
        .SEED    (32'hACE1_0001)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .use_ext     (use_ext),
        .ext_x       (ext_x),
        .ext_y       (ext_y),
        .num_req     (num_req),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_bits    (rsp_bits),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .resp_count  (resp_count),
        .checksum    (checksum),
        .last_result (last_result)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (req_valid && req_ready) fires <= fires + 1;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] nr, input logic ue,
                               input logic [31:0] ex, input logic [31:0] ey);
        num_req = nr;
        use_ext = ue;
        ext_x   = ex;
        ext_y   = ey;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Waits (bounded) for a request, optionally checks operands and their stability
    // while ready is held low, then completes exactly one handshake.
    task automatic fire(input string tag, input logic [31:0] ex, input logic [31:0] ey,
                        input int delay, input bit chk);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, req_valid}, 32'd1);
        if (chk) begin
            check({tag, "_x"}, req_x, ex);
            check({tag, "_y"}, req_y, ey);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_hold_valid"}, {31'd0, req_valid}, 32'd1);
            check({tag, "_hold_x"}, req_x, ex);
            check({tag, "_hold_y"}, req_y, ey);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, req_valid}, 32'd0);
    endtask

    // Result arrives five cycles after the fire edge.
    task automatic respond(input logic [31:0] v);
        repeat (4) tick();
        rsp_valid = 1'b1;
        rsp_bits  = v;
        tick();
        rsp_valid = 1'b0;
        rsp_bits  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        use_ext   = 1'b0;
        ext_x     = '0;
        ext_y     = '0;
        num_req   = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_bits  = '0;
        tick();
        tick();
        check("rst_valid", {31'd0, req_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_count", {16'd0, resp_count}, 32'd0);
        check("rst_sum", checksum, 32'd0);
        check("rst_last", last_result, 32'd0);
        check("rst_x", req_x, 32'd0);
        reset = 1'b1;
        tick();

        // LFSR operands from SEED, held stable under backpressure.
        f0 = fires;
        pulse_start(16'd1, 1'b0, 32'd0, 32'd0);
        check("lfsr_lat", {31'd0, req_valid}, 32'd1);
        fire("lfsr", 32'hACE1_0001, 32'h531E_FFFF, 10, 1'b1);
        check("lfsr_fires", fires - f0, 32'd1);
        respond(32'd1);
        check("lfsr_done", {31'd0, done}, 32'd1);

        // External operands, four requests.
        f0 = fires;
        pulse_start(16'd4, 1'b1, 32'd12, 32'd18);
        check("ext_lat", {31'd0, req_valid}, 32'd1);
        check("ext_busy", {31'd0, busy}, 32'd1);
        for (int r = 0; r < 4; r++) begin
            fire("ext", 32'd12, 32'd18, 0, 1'b1);
            respond(32'd6);
        end
        check("ext_fires", fires - f0, 32'd4);
        check("ext_done", {31'd0, done}, 32'd1);
        check("ext_count", {16'd0, resp_count}, 32'd4);
        check("ext_sum", checksum, 32'd24);
        check("ext_last", last_result, 32'd6);
        check("ext_error", {31'd0, error}, 32'd0);
        check("ext_busy_end", {31'd0, busy}, 32'd0);

        // start while busy is ignored.
        f0 = fires;
        pulse_start(16'd2, 1'b1, 32'd5, 32'd10);
        pulse_start(16'd9, 1'b1, 32'd7, 32'd7);
        fire("busy1", 32'd5, 32'd10, 0, 1'b1);
        respond(32'd5);
        fire("busy2", 32'd5, 32'd10, 0, 1'b1);
        respond(32'd5);
        check("busy_fires", fires - f0, 32'd2);
        check("busy_done", {31'd0, done}, 32'd1);
        check("busy_count", {16'd0, resp_count}, 32'd2);
        check("busy_sum", checksum, 32'd10);

        // Timeout: error exactly 16 cycles after fire.
        pulse_start(16'd1, 1'b1, 32'd3, 32'd4);
        fire("to", 32'd3, 32'd4, 0, 1'b1);
        repeat (15) tick();
        check("to_early", {31'd0, error}, 32'd0);
        tick();
        check("to_error", {31'd0, error}, 32'd1);
        check("to_valid", {31'd0, req_valid}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_count", {16'd0, resp_count}, 32'd0);

        // Spurious result in IDLE, then a zero-length run.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_bits  = 32'd7;
        tick();
        rsp_valid = 1'b0;
        rsp_bits  = '0;
        check("spur_error", {31'd0, error}, 32'd1);
        check("spur_sum", checksum, 32'd0);
        check("spur_last", last_result, 32'd0);
        pulse_start(16'd0, 1'b1, 32'd1, 32'd1);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_error", {31'd0, error}, 32'd0);
        check("zero_valid", {31'd0, req_valid}, 32'd0);

        // start and spurious result together in IDLE: error wins.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_bits  = 32'd7;
        pulse_start(16'd1, 1'b1, 32'd2, 32'd2);
        rsp_valid = 1'b0;
        rsp_bits  = '0;
        check("both_error", {31'd0, error}, 32'd1);
        check("both_valid", {31'd0, req_valid}, 32'd0);
        check("both_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset during WAIT of request 2 of 3.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        pulse_start(16'd3, 1'b0, 32'd0, 32'd0);
        fire("ar1", 32'hACE1_0001, 32'h531E_FFFF, 0, 1'b1);
        respond(32'd9);
        check("ar_sum_pre", checksum, 32'd9);
        fire("ar2", 32'd0, 32'd0, 0, 1'b0);
        tick();
        tick();
        check("ar_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_valid", {31'd0, req_valid}, 32'd0);
        check("ar_count", {16'd0, resp_count}, 32'd0);
        check("ar_sum", checksum, 32'd0);
        check("ar_last", last_result, 32'd0);
        check("ar_x", req_x, 32'd0);
        check("ar_y", req_y, 32'd0);
        check("ar_flags", {30'd0, done, error}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        pulse_start(16'd1, 1'b0, 32'd0, 32'd0);
        fire("ar_re", 32'hACE1_0001, 32'h531E_FFFF, 0, 1'b1);
        respond(32'd1);
        check("ar_re_done", {31'd0, done}, 32'd1);
        check("ar_re_count", {16'd0, resp_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
